// File: rtl/cmd_field_sequencer.sv
// Command FIFO plus segment sequencer: splits {Ctrl,Cnt} words and counts Cnt down on Tick.
// Optional build macro CMD_REPEAT_EN adds a Repeat input that reloads the last command when the FIFO runs dry.
module cmd_field_sequencer #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16,
    parameter int DEPTH  = 4
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [CTRL_W+CNT_W-1:0]      D,
    input  logic                         DValid,
    output logic                         DReady,
    input  logic                         Tick,
    input  logic                         Abort,
`ifdef CMD_REPEAT_EN
    input  logic                         Repeat,
`endif
    output logic [CTRL_W-1:0]            Ctrl,
    output logic [CNT_W-1:0]             Cnt,
    output logic                         Active,
    output logic                         Done,
    output logic [$clog2(DEPTH):0]       Level
);

    localparam int W     = CTRL_W + CNT_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]    level_q;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                fifo_full_s, fifo_empty_s, push_s;
    logic                pop_s, expire_s, reload_s, repeat_s;
    logic [W-1:0]        head_s;
    logic [CNT_W-1:0]    shadow_cnt_s;

    assign fifo_full_s  = (level_q == FULL_LVL);
    assign fifo_empty_s = (level_q == {LVL_W{1'b0}});
    assign head_s       = mem_q[rd_ptr_q];
    // A full FIFO refuses the word even if the sequencer pops in the same cycle.
    assign push_s       = DValid && !fifo_full_s && !Abort;

`ifdef CMD_REPEAT_EN
    logic [CNT_W-1:0] shadow_cnt_q;

    // Shadow copy of the last loaded count, used to replay the command.
    always_ff @(posedge Clk) begin
        if (Rst || Abort) begin
            shadow_cnt_q <= CNT_ZERO;
        end else if (pop_s) begin
            shadow_cnt_q <= head_s[CNT_W-1:0];
        end else begin
            shadow_cnt_q <= shadow_cnt_q;
        end
    end

    assign repeat_s     = Repeat;
    assign shadow_cnt_s = shadow_cnt_q;
`else
    assign repeat_s     = 1'b0;
    assign shadow_cnt_s = CNT_ZERO;
`endif

    // FIFO storage; data words need no reset because occupancy gates every read.
    always_ff @(posedge Clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= D;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge Clk) begin
        if (Rst || Abort) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LVL_W{1'b0}};
        end else begin
            wr_ptr_q <= push_s ? wr_ptr_q + {{(AW-1){1'b0}}, 1'b1} : wr_ptr_q;
            rd_ptr_q <= pop_s  ? rd_ptr_q + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   level_q <= level_q + {{(LVL_W-1){1'b0}}, 1'b1};
                2'b01:   level_q <= level_q - {{(LVL_W-1){1'b0}}, 1'b1};
                default: level_q <= level_q;
            endcase
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            ctrl_q  <= {CTRL_W{1'b0}};
            cnt_q   <= CNT_ZERO;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state: load from the FIFO when idle or on expiry, else replay or go idle.
    always_comb begin
        state_d  = state_q;
        pop_s    = 1'b0;
        expire_s = 1'b0;
        reload_s = 1'b0;
        if (Abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    expire_s = (cnt_q == CNT_ZERO) || (Tick && (cnt_q == CNT_ONE));
                    if (expire_s && !fifo_empty_s) begin
                        pop_s   = 1'b1;
                        state_d = ST_RUN;
                    end else if (expire_s && repeat_s) begin
                        reload_s = 1'b1;
                        state_d  = ST_RUN;
                    end else if (expire_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output datapath: field split on load, countdown on Tick, clear on expiry to idle.
    always_comb begin
        ctrl_d = ctrl_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (Abort) begin
            ctrl_d = {CTRL_W{1'b0}};
            cnt_d  = CNT_ZERO;
        end else if (pop_s) begin
            ctrl_d = head_s[W-1:CNT_W];
            cnt_d  = head_s[CNT_W-1:0];
            done_d = expire_s;
        end else if (expire_s) begin
            done_d = 1'b1;
            cnt_d  = reload_s ? shadow_cnt_s : CNT_ZERO;
        end else if ((state_q == ST_RUN) && Tick) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign DReady = !fifo_full_s;
    assign Ctrl   = ctrl_q;
    assign Cnt    = cnt_q;
    assign Active = (state_q == ST_RUN);
    assign Done   = done_q;
    assign Level  = level_q;

endmodule
